bullet_pool: RTL

//  Downstream of each tank: accepts fire pulses (normal/spread/pierce) with start

---
 rtl/bullet_pool_pkg.sv | 41 ++++
 rtl/bullet_pool_if.sv | 42 ++++
 rtl/bullet_pool_step.sv | 41 ++++
 rtl/bullet_pool.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pool_pkg.sv
// Shared constants and helpers for the bullet pool: direction codes, playfield
// bounds, sprite sizes, the spawn request payload and the bullet/tank overlap test.
package bullet_pool_pkg;

  localparam int unsigned COORD_W = 8;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int unsigned PF_MIN_X = 4;
  localparam int unsigned PF_MAX_X = 195;
  localparam int unsigned PF_MIN_Y = 4;
  localparam int unsigned PF_MAX_Y = 139;

  localparam int unsigned TANK_W    = 3;
  localparam int unsigned TANK_H    = 4;
  localparam int unsigned BULLET_SZ = 2;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         dir;
    logic               spread;
    logic               pierce;
  } spawn_req_t;

  // 2x2 bullet at (bx,by) overlaps the 3x4 tank box at (tx,ty); 9-bit to avoid wrap.
  function automatic logic box_hit(input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
                                   input logic [COORD_W-1:0] tx, input logic [COORD_W-1:0] ty);
    logic [COORD_W:0] bx9, by9, tx9, ty9;
    bx9 = {1'b0, bx};
    by9 = {1'b0, by};
    tx9 = {1'b0, tx};
    ty9 = {1'b0, ty};
    return (bx9 + 9'(BULLET_SZ - 1) >= tx9) && (bx9 <= tx9 + 9'(TANK_W - 1)) &&
           (by9 + 9'(BULLET_SZ - 1) >= ty9) && (by9 <= ty9 + 9'(TANK_H - 1));
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Bullet pool bus: game control, fire request, wall lookup, target and renderer export.
interface bullet_pool_if #(
  parameter int unsigned NUM_SLOTS = 4
);
  import bullet_pool_pkg::*;

  logic                           game_tick;
  logic                           clear;
  logic                           fire_bullet;
  logic                           fire_spread;
  logic                           fire_pierce;
  logic [COORD_W-1:0]             start_x;
  logic [COORD_W-1:0]             start_y;
  logic [1:0]                     start_dir;
  logic [COORD_W-1:0]             target_x;
  logic [COORD_W-1:0]             target_y;
  logic                           target_alive;
  logic [COORD_W-1:0]             check_x;
  logic [COORD_W-1:0]             check_y;
  logic                           hit_wall;
  logic                           hit_target;
  logic [NUM_SLOTS-1:0]           bullet_active;
  logic [COORD_W*NUM_SLOTS-1:0]   bullet_x_flat;
  logic [COORD_W*NUM_SLOTS-1:0]   bullet_y_flat;
  logic                           spawn_drop;
  logic                           tick_overrun;

  modport master (
    output game_tick, clear, fire_bullet, fire_spread, fire_pierce,
           start_x, start_y, start_dir, target_x, target_y, target_alive, hit_wall,
    input  check_x, check_y, hit_target, bullet_active, bullet_x_flat, bullet_y_flat,
           spawn_drop, tick_overrun
  );

  modport slave (
    input  game_tick, clear, fire_bullet, fire_spread, fire_pierce,
           start_x, start_y, start_dir, target_x, target_y, target_alive, hit_wall,
    output check_x, check_y, hit_target, bullet_active, bullet_x_flat, bullet_y_flat,
           spawn_drop, tick_overrun
  );

endinterface

// File: rtl/bullet_pool_step.sv
// One movement step of a bullet: next position, playfield bound check and the
// leading-edge point used for the wall lookup.
module bullet_pool_step
  import bullet_pool_pkg::*;
#(
  parameter int unsigned SPEED = 2,
  parameter int unsigned MIN_X = PF_MIN_X,
  parameter int unsigned MAX_X = PF_MAX_X,
  parameter int unsigned MIN_Y = PF_MIN_Y,
  parameter int unsigned MAX_Y = PF_MAX_Y
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] nx_c,
  output logic [COORD_W-1:0] ny_c,
  output logic [COORD_W-1:0] chk_x_c,
  output logic [COORD_W-1:0] chk_y_c,
  output logic               oob_c
);

  logic [COORD_W:0] nx9, ny9;

  // 9-bit move so an underflow lands above MAX and is caught by the same compare
  always_comb begin
    nx9 = {1'b0, x};
    ny9 = {1'b0, y};
    case (dir)
      DIR_UP:    ny9 = {1'b0, y} - 9'(SPEED);
      DIR_DOWN:  ny9 = {1'b0, y} + 9'(SPEED);
      DIR_LEFT:  nx9 = {1'b0, x} - 9'(SPEED);
      default:   nx9 = {1'b0, x} + 9'(SPEED);
    endcase
    nx_c    = nx9[COORD_W-1:0];
    ny_c    = ny9[COORD_W-1:0];
    oob_c   = (nx9 < 9'(MIN_X)) || (nx9 > 9'(MAX_X)) || (ny9 < 9'(MIN_Y)) || (ny9 > 9'(MAX_Y));
    chk_x_c = (dir == DIR_RIGHT) ? nx_c + 8'(BULLET_SZ - 1) : nx_c;
    chk_y_c = (dir == DIR_DOWN)  ? ny_c + 8'(BULLET_SZ - 1) : ny_c;
  end

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool for one tank: captures fire requests, spawns single/spread volleys,
// sweeps live bullets each game tick with wall lookup and opposing-tank hit detection.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned BULLET_SPEED = 2,
  parameter int unsigned MIN_X        = PF_MIN_X,
  parameter int unsigned MAX_X        = PF_MAX_X,
  parameter int unsigned MIN_Y        = PF_MIN_Y,
  parameter int unsigned MAX_Y        = PF_MAX_Y,
  parameter int unsigned SPREAD_OFS   = 2
) (
  input logic          clk,
  input logic          rstn,
  bullet_pool_if.slave bus
);

  localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SPAWN  = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                          state, state_nxt;
  logic [IW-1:0]                       idx;
  logic [NUM_SLOTS-1:0]                active;
  logic [NUM_SLOTS-1:0]                slot_pierce;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]   slot_x, slot_y;
  logic [NUM_SLOTS-1:0][1:0]           slot_dir;
  spawn_req_t                          pend;
  logic                                pend_valid, tick_pend, hit_seen;
  logic [COORD_W-1:0]                  check_x_q, check_y_q;
  logic                                hit_target_q, spawn_drop_q, tick_overrun_q;

  logic [COORD_W-1:0] nx, ny, chk_x, chk_y;
  logic               oob, last, tgt_hit;

  bullet_pool_step #(
    .SPEED(BULLET_SPEED), .MIN_X(MIN_X), .MAX_X(MAX_X), .MIN_Y(MIN_Y), .MAX_Y(MAX_Y)
  ) u_step (
    .x(slot_x[idx]), .y(slot_y[idx]), .dir(slot_dir[idx]),
    .nx_c(nx), .ny_c(ny), .chk_x_c(chk_x), .chk_y_c(chk_y), .oob_c(oob)
  );

  assign last    = (idx == IW'(NUM_SLOTS - 1));
  assign tgt_hit = bus.target_alive && box_hit(nx, ny, bus.target_x, bus.target_y);

  // Lowest three free slots, in placement order centre / side A / side B
  logic [NUM_SLOTS-1:0]  free_w;
  logic [2:0]            pick_ok;
  logic [IW-1:0]         pick_idx [3];
  logic [COORD_W-1:0]    sp_x [3];
  logic [COORD_W-1:0]    sp_y [3];
  logic                  spawn_short;

  always_comb begin
    free_w = ~active;
    for (int k = 0; k < 3; k++) begin
      pick_ok[k]  = 1'b0;
      pick_idx[k] = '0;
      for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
        if (free_w[i]) begin
          pick_ok[k]  = 1'b1;
          pick_idx[k] = IW'(i);
        end
      end
      if (pick_ok[k]) free_w[pick_idx[k]] = 1'b0;
    end
    sp_x[0] = pend.x;
    sp_y[0] = pend.y;
    if (pend.dir == DIR_UP || pend.dir == DIR_DOWN) begin
      sp_x[1] = pend.x - 8'(SPREAD_OFS);
      sp_x[2] = pend.x + 8'(SPREAD_OFS);
      sp_y[1] = pend.y;
      sp_y[2] = pend.y;
    end else begin
      sp_x[1] = pend.x;
      sp_x[2] = pend.x;
      sp_y[1] = pend.y - 8'(SPREAD_OFS);
      sp_y[2] = pend.y + 8'(SPREAD_OFS);
    end
    spawn_short = !pick_ok[0] || (pend.spread && !(pick_ok[1] && pick_ok[2]));
  end

  always_ff @(posedge clk) begin
    if (!rstn || bus.clear) state <= S_IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pend_valid)         state_nxt = S_SPAWN;
        else if (bus.game_tick) state_nxt = S_SCAN;
      end
      S_SPAWN:  state_nxt = tick_pend ? S_SCAN : S_IDLE;
      S_SCAN: begin
        if (active[idx] && !oob) state_nxt = S_CHECK;
        else if (last)           state_nxt = S_DONE;
      end
      S_CHECK:  state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last ? S_DONE : S_SCAN;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || bus.clear) begin
      active       <= '0;
      slot_pierce  <= '0;
      slot_x       <= '0;
      slot_y       <= '0;
      slot_dir     <= '0;
      pend         <= '0;
      pend_valid   <= 1'b0;
      tick_pend    <= 1'b0;
      hit_seen     <= 1'b0;
      idx          <= '0;
      check_x_q    <= '0;
      check_y_q    <= '0;
      hit_target_q <= 1'b0;
      spawn_drop_q <= 1'b0;
    end else begin
      hit_target_q <= 1'b0;
      spawn_drop_q <= 1'b0;
      case (state)
        S_IDLE: begin
          idx      <= '0;
          hit_seen <= 1'b0;
          if (pend_valid && bus.game_tick) tick_pend <= 1'b1;
        end
        S_SPAWN: begin
          idx        <= '0;
          hit_seen   <= 1'b0;
          tick_pend  <= 1'b0;
          pend_valid <= 1'b0;
          for (int k = 0; k < 3; k++) begin
            if (pick_ok[k] && (k == 0 || pend.spread)) begin
              active[pick_idx[k]]      <= 1'b1;
              slot_x[pick_idx[k]]      <= sp_x[k];
              slot_y[pick_idx[k]]      <= sp_y[k];
              slot_dir[pick_idx[k]]    <= pend.dir;
              slot_pierce[pick_idx[k]] <= pend.pierce;
            end
          end
          if (spawn_short) spawn_drop_q <= 1'b1;
        end
        S_SCAN: begin
          if (!active[idx] || oob) begin
            active[idx] <= 1'b0;
            if (!last) idx <= idx + IW'(1);
          end else begin
            check_x_q <= chk_x;
            check_y_q <= chk_y;
          end
        end
        S_SAMPLE: begin
          if (bus.hit_wall && !slot_pierce[idx]) begin
            active[idx] <= 1'b0;
          end else if (tgt_hit) begin
            active[idx] <= 1'b0;
            hit_seen    <= 1'b1;
          end else begin
            slot_x[idx] <= nx;
            slot_y[idx] <= ny;
          end
          if (!last) idx <= idx + IW'(1);
        end
        S_DONE: hit_target_q <= hit_seen;
        default: ;
      endcase
      // Capture after the SPAWN consume so a request arriving that cycle is kept
      if (bus.fire_bullet) begin
        if (!pend_valid || state == S_SPAWN) begin
          pend       <= '{x: bus.start_x, y: bus.start_y, dir: bus.start_dir,
                          spread: bus.fire_spread, pierce: bus.fire_pierce};
          pend_valid <= 1'b1;
        end else begin
          spawn_drop_q <= 1'b1;
        end
      end
    end
  end

  // Sticky overrun survives a round clear
  always_ff @(posedge clk) begin
    if (!rstn)                              tick_overrun_q <= 1'b0;
    else if (bus.game_tick && state != S_IDLE) tick_overrun_q <= 1'b1;
  end

  assign bus.check_x       = check_x_q;
  assign bus.check_y       = check_y_q;
  assign bus.hit_target    = hit_target_q;
  assign bus.spawn_drop    = spawn_drop_q;
  assign bus.tick_overrun  = tick_overrun_q;
  assign bus.bullet_active = active;
  assign bus.bullet_x_flat = slot_x;
  assign bus.bullet_y_flat = slot_y;

endmodule
